// File: rtl/wbarbiter_n.sv
// wbarbiter_n: N-master Wishbone pipelined arbiter.
// Round-robin or fixed priority, outstanding-request cap, optional timeout abort.
module wbarbiter_n #(
  parameter int    NM = 4,
  parameter int    DW = 32,
  parameter int    AW = 32,
  parameter string SCHEME = "ROUNDROBIN",
  parameter bit    OPT_ZERO_ON_IDLE = 1'b0,
  parameter int    LGMAXOUT = 4,
  parameter int    TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NM-1:0]     i_m_cyc,
  input  logic [NM-1:0]     i_m_stb,
  input  logic [NM-1:0]     i_m_we,
  input  logic [NM*AW-1:0]  i_m_adr,
  input  logic [NM*DW-1:0]  i_m_dat,
  input  logic [NM*DW/8-1:0] i_m_sel,
  output logic [NM-1:0]     o_m_ack,
  output logic [NM-1:0]     o_m_stall,
  output logic [NM-1:0]     o_m_err,
  output logic              o_cyc,
  output logic              o_stb,
  output logic              o_we,
  output logic [AW-1:0]     o_adr,
  output logic [DW-1:0]     o_dat,
  output logic [DW/8-1:0]   o_sel,
  input  logic              i_ack,
  input  logic              i_stall,
  input  logic              i_err,
  output logic [NM-1:0]     o_grant
);

  localparam int LGNM = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit RR = (SCHEME == "ROUNDROBIN");
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ABORT
  } state_t;

  state_t            state, state_nx;
  logic [LGNM-1:0]   owner, owner_nx;
  logic [LGNM-1:0]   ptr, ptr_nx;
  logic [NM-1:0]     grant_nx;
  logic [LGMAXOUT-1:0] nout, nout_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              err_pulse, err_pulse_nx;

  logic [NM-1:0]     req;
  logic [LGNM-1:0]   win;
  logic              win_vld;
  logic [LGNM-1:0]   k;

  logic              live, cyc_w, full, zero;
  logic              acc, dec, counting;

  logic [AW-1:0]     adr_a [NM];
  logic [DW-1:0]     dat_a [NM];
  logic [SW-1:0]     sel_a [NM];

  for (genvar g = 0; g < NM; g++) begin : g_unpack
    assign adr_a[g] = i_m_adr[g*AW +: AW];
    assign dat_a[g] = i_m_dat[g*DW +: DW];
    assign sel_a[g] = i_m_sel[g*SW +: SW];
  end

  assign req = i_m_cyc & i_m_stb;

  // Scan downward so the last hit is the closest one above ptr.
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    k = '0;
    if (RR) begin
      for (int i = NM; i >= 1; i--) begin
        k = LGNM'((int'(ptr) + i) % NM);
        if (req[k]) begin
          win = k;
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (req[i]) begin
          win = LGNM'(i);
          win_vld = 1'b1;
        end
      end
    end
  end

  assign live = (state == S_GRANT) && !i_reset;
  assign cyc_w = i_m_cyc[owner];
  assign full = &nout;

  assign o_cyc = live && cyc_w;
  assign o_stb = o_cyc && i_m_stb[owner] && !full;
  assign zero = OPT_ZERO_ON_IDLE && !o_cyc;
  assign o_we = !zero && i_m_we[owner];
  assign o_adr = zero ? '0 : adr_a[owner];
  assign o_dat = zero ? '0 : dat_a[owner];
  assign o_sel = zero ? '0 : sel_a[owner];

  assign acc = o_stb && !i_stall;
  assign dec = i_ack && (nout != '0);
  assign counting = (nout != '0) && !i_ack && !i_err;

  always_comb begin
    o_m_stall = '1;
    o_m_ack = '0;
    o_m_err = '0;
    if (live) begin
      o_m_stall[owner] = i_stall || full;
      o_m_ack[owner] = i_ack;
      o_m_err[owner] = i_err;
    end else if (state == S_ABORT && !i_reset) begin
      o_m_err[owner] = err_pulse;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx = ptr;
    grant_nx = o_grant;
    nout_nx = nout;
    timer_nx = '0;
    err_pulse_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_nx = S_GRANT;
          owner_nx = win;
          ptr_nx = win;
          grant_nx = NM'(1) << win;
        end
      end
      S_GRANT: begin
        if (!cyc_w) begin
          state_nx = S_IDLE;
          grant_nx = '0;
          nout_nx = '0;
        end else if (TIMEOUT > 0 && counting && timer == TMAX) begin
          state_nx = S_ABORT;
          nout_nx = '0;
          err_pulse_nx = 1'b1;
        end else begin
          if (i_err)
            nout_nx = '0;
          else if (acc && !dec)
            nout_nx = nout + 1'b1;
          else if (!acc && dec)
            nout_nx = nout - 1'b1;
          if (counting)
            timer_nx = timer + 1'b1;
        end
      end
      S_ABORT: begin
        if (!cyc_w) begin
          state_nx = S_IDLE;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
        nout_nx = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      owner <= '0;
      ptr <= LGNM'(NM - 1);
      o_grant <= '0;
      nout <= '0;
      timer <= '0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr <= ptr_nx;
      o_grant <= grant_nx;
      nout <= nout_nx;
      timer <= timer_nx;
      err_pulse <= err_pulse_nx;
    end
  end

endmodule

// File: tb/tb_wbarbiter_n.sv
// tb_wbarbiter_n: directed bench for the N-master Wishbone arbiter.
// Three instances: round-robin, priority (zero-on-idle), round-robin with timeout.
module tb_wbarbiter_n;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic ack, stall, err;

  logic [NM-1:0] r_ack, r_stall, r_err, r_grant;
  logic r_cyc, r_stb, r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic [SW-1:0] r_sel;

  logic [NM-1:0] p_ack, p_stall, p_err, p_grant;
  logic p_cyc, p_stb, p_we;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_dat;
  logic [SW-1:0] p_sel;

  logic [NM-1:0] t_ack, t_stall, t_err, t_grant;
  logic t_cyc, t_stb, t_we;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_dat;
  logic [SW-1:0] t_sel;

  int checks = 0;
  int failures = 0;

  wbarbiter_n #(
    .NM(NM), .DW(DW), .AW(AW), .SCHEME("ROUNDROBIN"),
    .OPT_ZERO_ON_IDLE(1'b0), .LGMAXOUT(4), .TIMEOUT(0)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(r_ack), .o_m_stall(r_stall), .o_m_err(r_err),
    .o_cyc(r_cyc), .o_stb(r_stb), .o_we(r_we),
    .o_adr(r_adr), .o_dat(r_dat), .o_sel(r_sel),
    .i_ack(ack), .i_stall(stall), .i_err(err),
    .o_grant(r_grant)
  );

  wbarbiter_n #(
    .NM(NM), .DW(DW), .AW(AW), .SCHEME("PRIORITY"),
    .OPT_ZERO_ON_IDLE(1'b1), .LGMAXOUT(4), .TIMEOUT(0)
  ) dut_pr (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(p_ack), .o_m_stall(p_stall), .o_m_err(p_err),
    .o_cyc(p_cyc), .o_stb(p_stb), .o_we(p_we),
    .o_adr(p_adr), .o_dat(p_dat), .o_sel(p_sel),
    .i_ack(ack), .i_stall(stall), .i_err(err),
    .o_grant(p_grant)
  );

  wbarbiter_n #(
    .NM(NM), .DW(DW), .AW(AW), .SCHEME("ROUNDROBIN"),
    .OPT_ZERO_ON_IDLE(1'b0), .LGMAXOUT(4), .TIMEOUT(8)
  ) dut_to (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(t_ack), .o_m_stall(t_stall), .o_m_err(t_err),
    .o_cyc(t_cyc), .o_stb(t_stb), .o_we(t_we),
    .o_adr(t_adr), .o_dat(t_dat), .o_sel(t_sel),
    .i_ack(ack), .i_stall(stall), .i_err(err),
    .o_grant(t_grant)
  );

  task automatic clr_inputs;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    ack = 1'b0; stall = 1'b0; err = 1'b0;
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    next;
    clr_inputs;
    rst = 1'b1;
    next;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    next;
    next;
    m_cyc = '1; m_stb = '1;
    m_adr = {NM{32'hDEAD_BEEF}};
    ack = 1'b1; err = 1'b1;
    #1;
    checks++;
    if (r_grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_grant got=%b exp=0000", r_grant);
    end
    checks++;
    if (r_cyc !== 1'b0) begin
      failures++;
      $display("FAIL reset_cyc got=%b exp=0", r_cyc);
    end
    checks++;
    if (r_stall !== 4'b1111) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=1111", r_stall);
    end
    checks++;
    if (r_ack !== 4'b0000 || r_err !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ack_err got=%b/%b exp=0000/0000", r_ack, r_err);
    end
    checks++;
    if (p_stb !== 1'b0 || p_adr !== 32'h0) begin
      failures++;
      $display("FAIL reset_zero_idle got=%b/%h exp=0/0", p_stb, p_adr);
    end
    checks++;
    if (t_grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_grant_to got=%b exp=0000", t_grant);
    end
    next;
    rst = 1'b0;
    clr_inputs;
  endtask

  task automatic test_single;
    do_reset;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    m_adr[2*AW +: AW] = 32'h10;
    m_sel[2*SW +: SW] = 4'hF;
    #1;
    checks++;
    if (r_grant !== 4'b0000 || r_stall !== 4'b1111) begin
      failures++;
      $display("FAIL single_idle got=%b/%b exp=0000/1111", r_grant, r_stall);
    end
    next; #1;
    checks++;
    if (r_grant !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got=%b exp=0100", r_grant);
    end
    checks++;
    if (r_cyc !== 1'b1 || r_stb !== 1'b1 || r_we !== 1'b0) begin
      failures++;
      $display("FAIL single_bus got=%b%b%b exp=110", r_cyc, r_stb, r_we);
    end
    checks++;
    if (r_adr !== 32'h10 || r_sel !== 4'hF) begin
      failures++;
      $display("FAIL single_adr got=%h/%h exp=10/f", r_adr, r_sel);
    end
    checks++;
    if (r_stall !== 4'b1011) begin
      failures++;
      $display("FAIL single_stall got=%b exp=1011", r_stall);
    end
    next; m_stb[2] = 1'b0; #1;
    checks++;
    if (r_stb !== 1'b0 || r_ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_wait got=%b/%b exp=0/0000", r_stb, r_ack);
    end
    next; ack = 1'b1; #1;
    checks++;
    if (r_ack !== 4'b0100) begin
      failures++;
      $display("FAIL single_ack got=%b exp=0100", r_ack);
    end
    next; ack = 1'b0; m_cyc[2] = 1'b0; #1;
    checks++;
    if (r_ack !== 4'b0000 || r_cyc !== 1'b0) begin
      failures++;
      $display("FAIL single_release got=%b/%b exp=0000/0", r_ack, r_cyc);
    end
    next; #1;
    checks++;
    if (r_grant !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle_after got=%b exp=0000", r_grant);
    end
  endtask

  task automatic test_round_robin;
    int seq [6];
    seq = '{0, 1, 3, 0, 1, 3};
    do_reset;
    m_cyc = 4'b1011; m_stb = 4'b1011;
    for (int n = 0; n < 6; n++) begin
      int w;
      w = seq[n];
      next; #1;
      checks++;
      if (r_grant !== 4'(1 << w)) begin
        failures++;
        $display("FAIL rr_grant n=%0d got=%b exp=%b", n, r_grant, 4'(1 << w));
      end
      next; m_stb[w] = 1'b0; ack = 1'b1; #1;
      checks++;
      if (r_ack !== 4'(1 << w)) begin
        failures++;
        $display("FAIL rr_ack n=%0d got=%b exp=%b", n, r_ack, 4'(1 << w));
      end
      next; ack = 1'b0; m_cyc[w] = 1'b0; #1;
      checks++;
      if (r_cyc !== 1'b0) begin
        failures++;
        $display("FAIL rr_release n=%0d got=%b exp=0", n, r_cyc);
      end
      next; m_cyc[w] = 1'b1; m_stb[w] = 1'b1; #1;
      checks++;
      if (r_grant !== 4'b0000 || r_cyc !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap n=%0d got=%b/%b exp=0000/0", n, r_grant, r_cyc);
      end
    end
    clr_inputs;
  endtask

  task automatic test_priority;
    int seq [5];
    seq = '{0, 0, 0, 1, 3};
    do_reset;
    m_cyc = 4'b1011; m_stb = 4'b1011;
    m_adr = {NM{32'h0000_5A5A}};
    for (int n = 0; n < 5; n++) begin
      int w;
      w = seq[n];
      next; #1;
      checks++;
      if (p_grant !== 4'(1 << w)) begin
        failures++;
        $display("FAIL pr_grant n=%0d got=%b exp=%b", n, p_grant, 4'(1 << w));
      end
      next; m_stb[w] = 1'b0; ack = 1'b1; #1;
      checks++;
      if (p_ack !== 4'(1 << w)) begin
        failures++;
        $display("FAIL pr_ack n=%0d got=%b exp=%b", n, p_ack, 4'(1 << w));
      end
      next; ack = 1'b0; m_cyc[w] = 1'b0; #1;
      checks++;
      if (p_cyc !== 1'b0 || p_adr !== 32'h0) begin
        failures++;
        $display("FAIL pr_release n=%0d got=%b/%h exp=0/0", n, p_cyc, p_adr);
      end
      next;
      if (w == 0 && n < 2) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      end
      #1;
      checks++;
      if (p_grant !== 4'b0000 || p_cyc !== 1'b0) begin
        failures++;
        $display("FAIL pr_gap n=%0d got=%b/%b exp=0000/0", n, p_grant, p_cyc);
      end
    end
    clr_inputs;
  endtask

  task automatic test_pipeline;
    int sent, acked, outs, maxo;
    logic exp_stall, exp_stb;
    sent = 0; acked = 0; outs = 0; maxo = 0;
    do_reset;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    next;
    for (int c = 0; c < 80 && acked < 20; c++) begin
      m_stb[0] = (sent < 20);
      ack = (c >= 18) && (outs > 0);
      #1;
      exp_stall = (outs == 15);
      exp_stb = m_stb[0] && !exp_stall;
      checks++;
      if (r_stall[0] !== exp_stall) begin
        failures++;
        $display("FAIL pipe_stall c=%0d got=%b exp=%b", c, r_stall[0], exp_stall);
      end
      checks++;
      if (r_stb !== exp_stb) begin
        failures++;
        $display("FAIL pipe_stb c=%0d got=%b exp=%b", c, r_stb, exp_stb);
      end
      checks++;
      if (r_ack[0] !== ack) begin
        failures++;
        $display("FAIL pipe_ack c=%0d got=%b exp=%b", c, r_ack[0], ack);
      end
      sent += int'(exp_stb);
      acked += int'(ack);
      outs = outs + int'(exp_stb) - int'(ack);
      if (outs > maxo) maxo = outs;
      next;
    end
    checks++;
    if (acked != 20 || sent != 20) begin
      failures++;
      $display("FAIL pipe_total got=%0d/%0d exp=20/20", sent, acked);
    end
    checks++;
    if (maxo != 15) begin
      failures++;
      $display("FAIL pipe_maxout got=%0d exp=15", maxo);
    end
    clr_inputs;
  endtask

  task automatic test_timeout;
    do_reset;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    next; #1;
    checks++;
    if (t_grant !== 4'b0010 || t_stb !== 1'b1) begin
      failures++;
      $display("FAIL to_grant got=%b/%b exp=0010/1", t_grant, t_stb);
    end
    for (int c = 2; c <= 9; c++) begin
      next; m_stb[1] = 1'b0; #1;
      checks++;
      if (t_err !== 4'b0000 || t_cyc !== 1'b1) begin
        failures++;
        $display("FAIL to_wait c=%0d got=%b/%b exp=0000/1", c, t_err, t_cyc);
      end
    end
    next; #1;
    checks++;
    if (t_err !== 4'b0010 || t_cyc !== 1'b0) begin
      failures++;
      $display("FAIL to_err got=%b/%b exp=0010/0", t_err, t_cyc);
    end
    next; #1;
    checks++;
    if (t_err !== 4'b0000 || t_cyc !== 1'b0 || t_stall[1] !== 1'b1) begin
      failures++;
      $display("FAIL to_abort got=%b/%b/%b exp=0000/0/1", t_err, t_cyc, t_stall[1]);
    end
    next; m_cyc[1] = 1'b0; #1;
    checks++;
    if (t_cyc !== 1'b0 || t_grant !== 4'b0010) begin
      failures++;
      $display("FAIL to_hold got=%b/%b exp=0/0010", t_cyc, t_grant);
    end
    next; #1;
    checks++;
    if (t_grant !== 4'b0000) begin
      failures++;
      $display("FAIL to_idle got=%b exp=0000", t_grant);
    end
    clr_inputs;
  endtask

  task automatic test_reset_mid;
    do_reset;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    next; next; next; #1;
    checks++;
    if (r_stb !== 1'b1 || r_stall[2] !== 1'b0) begin
      failures++;
      $display("FAIL rmid_busy got=%b/%b exp=1/0", r_stb, r_stall[2]);
    end
    next; m_stb[2] = 1'b0; rst = 1'b1; #1;
    checks++;
    if (r_cyc !== 1'b0) begin
      failures++;
      $display("FAIL rmid_cyc_in_reset got=%b exp=0", r_cyc);
    end
    next; rst = 1'b0; ack = 1'b1; #1;
    checks++;
    if (r_grant !== 4'b0000 || r_cyc !== 1'b0) begin
      failures++;
      $display("FAIL rmid_idle got=%b/%b exp=0000/0", r_grant, r_cyc);
    end
    checks++;
    if (r_ack !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_ack got=%b exp=0000", r_ack);
    end
    next; #1;
    checks++;
    if (r_ack !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_ack2 got=%b exp=0000", r_ack);
    end
    clr_inputs;
  endtask

  task automatic test_error;
    do_reset;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    next; next; next; next; #1;
    checks++;
    if (r_stall[0] !== 1'b0 || r_stb !== 1'b1) begin
      failures++;
      $display("FAIL err_issue got=%b/%b exp=0/1", r_stall[0], r_stb);
    end
    next; m_stb[0] = 1'b0; ack = 1'b1; #1;
    checks++;
    if (r_ack !== 4'b0001) begin
      failures++;
      $display("FAIL err_first_ack got=%b exp=0001", r_ack);
    end
    next; ack = 1'b0; err = 1'b1; #1;
    checks++;
    if (r_err !== 4'b0001 || r_ack !== 4'b0000) begin
      failures++;
      $display("FAIL err_fwd got=%b/%b exp=0001/0000", r_err, r_ack);
    end
    next; err = 1'b0; ack = 1'b1; #1;
    checks++;
    if (dut.nout !== 4'd0) begin
      failures++;
      $display("FAIL err_cnt_cleared got=%0d exp=0", dut.nout);
    end
    checks++;
    if (r_ack !== 4'b0001) begin
      failures++;
      $display("FAIL err_late_ack got=%b exp=0001", r_ack);
    end
    next; #1;
    next; ack = 1'b0; m_stb[0] = 1'b1; #1;
    checks++;
    if (dut.nout !== 4'd0) begin
      failures++;
      $display("FAIL err_no_underflow got=%0d exp=0", dut.nout);
    end
    checks++;
    if (r_stall[0] !== 1'b0 || r_stb !== 1'b1) begin
      failures++;
      $display("FAIL err_after got=%b/%b exp=0/1", r_stall[0], r_stb);
    end
    clr_inputs;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs;
    test_reset;
    test_single;
    test_round_robin;
    test_priority;
    test_pipeline;
    test_timeout;
    test_reset_mid;
    test_error;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
